// File: rtl/nar_pkg.sv
// Shared definitions for the neuron sequencer: default fixed-point format,
// sequencer state encoding and a width helper.
package nar_pkg;

  localparam int N_DEF = 10;
  localparam int Q_DEF = 9;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_FILL    = 3'd2,
    S_MAC     = 3'd3,
    S_CAPTURE = 3'd4,
    S_DONE    = 3'd5
  } seq_state_t;

  // Address width for a memory of v entries, never narrower than one bit.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/mac_addr_gen.sv
// Address counters for the time-multiplexed neuron: fan-in index j, running
// weight address and neuron index k, plus the last-element flags.
module mac_addr_gen
  import nar_pkg::*;
#(
  parameter int NUM_IN      = 4,
  parameter int NUM_NEURONS = 3,
  parameter int WAW         = clog2_min1(NUM_IN * NUM_NEURONS),
  parameter int XAW         = clog2_min1(NUM_IN),
  parameter int BAW         = clog2_min1(NUM_NEURONS)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr_i,
  input  logic           fill_i,
  input  logic           mac_i,
  input  logic           capture_i,
  output logic [WAW-1:0] w_addr_o,
  output logic [XAW-1:0] x_addr_o,
  output logic [BAW-1:0] b_addr_o,
  output logic           last_j_o,
  output logic           last_k_o
);

  localparam logic [XAW-1:0] J_LAST = XAW'(NUM_IN - 1);
  localparam logic [BAW-1:0] K_LAST = BAW'(NUM_NEURONS - 1);

  logic [XAW-1:0] i_q, i_d;
  logic [XAW-1:0] j_q, j_d;
  logic [WAW-1:0] w_q, w_d;
  logic [BAW-1:0] k_q, k_d;

  assign last_j_o = (i_q == J_LAST);
  assign last_k_o = (k_q == K_LAST);
  assign w_addr_o = w_q;
  assign x_addr_o = j_q;
  assign b_addr_o = k_q;

  // The issued address runs one element ahead of the MAC index i and
  // saturates at the last element, so the final MAC cycle holds it.
  always_comb begin
    i_d = i_q;
    j_d = j_q;
    w_d = w_q;
    k_d = k_q;
    if (clr_i) begin
      i_d = '0;
      j_d = '0;
      w_d = '0;
      k_d = '0;
    end else begin
      if ((fill_i || mac_i) && (j_q != J_LAST)) begin
        j_d = j_q + 1'b1;
        w_d = w_q + 1'b1;
      end
      if (mac_i) begin
        i_d = last_j_o ? '0 : i_q + 1'b1;
      end
      // Step past the held last weight onto the next neuron's row.
      if (capture_i) begin
        j_d = '0;
        w_d = w_q + 1'b1;
        if (!last_k_o) begin
          k_d = k_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      i_q <= '0;
      j_q <= '0;
      w_q <= '0;
      k_q <= '0;
    end else begin
      i_q <= i_d;
      j_q <= j_d;
      w_q <= w_d;
      k_q <= k_d;
    end
  end

endmodule

// File: rtl/neuron_seq.sv
// Sequencer that evaluates a fully connected layer on a single neuron MAC
// unit, driving memory addresses and neuron strobes and registering results.
module neuron_seq
  import nar_pkg::*;
#(
  parameter int N           = N_DEF,
  parameter int Q           = Q_DEF,
  parameter int NUM_IN      = 4,
  parameter int NUM_NEURONS = 3,
  parameter int WAW         = clog2_min1(NUM_IN * NUM_NEURONS),
  parameter int XAW         = clog2_min1(NUM_IN),
  parameter int BAW         = clog2_min1(NUM_NEURONS)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic [WAW-1:0] w_addr,
  output logic [XAW-1:0] x_addr,
  output logic [BAW-1:0] b_addr,
  output logic           neuron_rst,
  output logic           neuron_inpt_ready,
  input  logic [N-1:0]   neuron_out,
  output logic           y_valid,
  output logic [BAW-1:0] y_idx,
  output logic [N-1:0]   y_data
);

  if (NUM_IN < 1 || NUM_NEURONS < 1 || Q >= N) begin : g_bad_param
    $error("neuron_seq: invalid parameter set");
  end

  seq_state_t state_q, state_d;

  logic clr_cnt, fill_en, mac_en, capture_en;
  logic last_j, last_k;

  logic           y_valid_q;
  logic [BAW-1:0] y_idx_q;
  logic [N-1:0]   y_data_q;

  mac_addr_gen #(
    .NUM_IN      (NUM_IN),
    .NUM_NEURONS (NUM_NEURONS),
    .WAW         (WAW),
    .XAW         (XAW),
    .BAW         (BAW)
  ) u_addr (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (clr_cnt),
    .fill_i    (fill_en),
    .mac_i     (mac_en),
    .capture_i (capture_en),
    .w_addr_o  (w_addr),
    .x_addr_o  (x_addr),
    .b_addr_o  (b_addr),
    .last_j_o  (last_j),
    .last_k_o  (last_k)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (start) state_d = S_CLEAR;
      S_CLEAR:   state_d = S_FILL;
      S_FILL:    state_d = S_MAC;
      S_MAC:     if (last_j) state_d = S_CAPTURE;
      S_CAPTURE: state_d = last_k ? S_DONE : S_CLEAR;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // The neuron is held in reset while idle so it never picks up a stray bias;
  // its bias is added on the FILL edge, when inpt_ready is low.
  always_comb begin
    busy              = (state_q != S_IDLE);
    done              = (state_q == S_DONE);
    neuron_rst        = (state_q == S_IDLE) || (state_q == S_CLEAR);
    neuron_inpt_ready = (state_q == S_MAC);
    fill_en           = (state_q == S_FILL);
    mac_en            = (state_q == S_MAC);
    capture_en        = (state_q == S_CAPTURE);
    clr_cnt           = ((state_q == S_IDLE) && start) || (state_q == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_valid_q <= 1'b0;
      y_idx_q   <= '0;
      y_data_q  <= '0;
    end else begin
      y_valid_q <= capture_en;
      if (capture_en) begin
        y_idx_q  <= b_addr;
        y_data_q <= neuron_out;
      end
    end
  end

  assign y_valid = y_valid_q;
  assign y_idx   = y_idx_q;
  assign y_data  = y_data_q;

endmodule

// File: tb/tb_neuron_seq.sv
// Bench for neuron_seq: behavioural memories and neuron around the sequencer,
// results compared against a per-neuron dot-product reference.
module tb_neuron_seq;
  import nar_pkg::*;

  localparam int N    = 10;
  localparam int Q    = 9;
  localparam int NI   = 2;
  localparam int NN   = 2;
  localparam int WAW  = clog2_min1(NI * NN);
  localparam int XAW  = clog2_min1(NI);
  localparam int BAW  = clog2_min1(NN);
  localparam int P    = NI + 3;
  localparam int LAST = NN * P + 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           busy, done, neuron_rst, neuron_inpt_ready, y_valid;
  logic [WAW-1:0] w_addr;
  logic [XAW-1:0] x_addr;
  logic [BAW-1:0] b_addr;
  logic [BAW-1:0] y_idx;
  logic [N-1:0]   y_data;
  logic [N-1:0]   neuron_out;

  always #5 clk = ~clk;

  neuron_seq #(
    .N           (N),
    .Q           (Q),
    .NUM_IN      (NI),
    .NUM_NEURONS (NN)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .busy              (busy),
    .done              (done),
    .w_addr            (w_addr),
    .x_addr            (x_addr),
    .b_addr            (b_addr),
    .neuron_rst        (neuron_rst),
    .neuron_inpt_ready (neuron_inpt_ready),
    .neuron_out        (neuron_out),
    .y_valid           (y_valid),
    .y_idx             (y_idx),
    .y_data            (y_data)
  );

  logic signed [N-1:0] w_mem [NI*NN];
  logic signed [N-1:0] x_mem [NI];
  logic signed [N-1:0] b_mem [NN];
  logic signed [N-1:0] w_rd, x_rd, b_rd;
  longint acc = 0;
  bit     bias_done = 1'b0;

  function automatic logic signed [N-1:0] sat(input longint v);
    longint hi = (longint'(1) <<< (N - 1)) - 1;
    longint lo = -(longint'(1) <<< (N - 1));
    if (v > hi) return N'(hi);
    if (v < lo) return N'(lo);
    return N'(v);
  endfunction

  // Synchronous-read memories and the neuron the sequencer drives.
  always @(posedge clk) begin
    w_rd <= w_mem[w_addr];
    x_rd <= x_mem[x_addr];
    b_rd <= b_mem[b_addr];
  end

  always @(posedge clk) begin
    if (neuron_rst) begin
      acc       <= 0;
      bias_done <= 1'b0;
    end else if (neuron_inpt_ready) begin
      acc <= acc + longint'(w_rd) * longint'(x_rd);
    end else if (!bias_done) begin
      acc       <= acc + (longint'(b_rd) <<< Q);
      bias_done <= 1'b1;
    end
  end

  assign neuron_out = sat(acc >>> Q);

  function automatic longint ref_y(input int k);
    longint s = longint'(b_mem[k]) <<< Q;
    for (int j = 0; j < NI; j++) s += longint'(w_mem[k*NI + j]) * longint'(x_mem[j]);
    return longint'(sat(s >>> Q));
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Runs one layer from an IDLE negedge (cycle 0 = start sampled), checking
  // every cycle. busy_rel pulses start mid-run; rst_rel drops rst_n.
  task automatic run(input string name, input int busy_rel, input int rst_rel);
    for (int rel = 0; rel <= LAST; rel++) begin
      bit aborted = (rst_rel >= 0) && (rel > rst_rel);
      bit in_run  = (rel >= 1) && (rel <= NN * P);
      int k       = (rel >= 1) ? (rel - 1) / P : 0;
      int ph      = (rel >= 1) ? (rel - 1) % P : 0;
      bit e_busy  = !aborted && (rel >= 1) && (rel <= LAST);
      bit e_done  = !aborted && (rel == LAST);
      bit e_yv    = !aborted && (rel > P) && ((rel - 1) % P == 0);
      bit e_rdy   = !aborted && in_run && (ph >= 2) && (ph <= NI + 1);
      bit e_nrst  = aborted || (rel == 0) || (in_run && ph == 0);
      int jj      = (ph - 1 < NI - 1) ? ph - 1 : NI - 1;

      chk($sformatf("%s busy@%0d", name, rel), longint'(busy), longint'(e_busy));
      chk($sformatf("%s done@%0d", name, rel), longint'(done), longint'(e_done));
      chk($sformatf("%s y_valid@%0d", name, rel), longint'(y_valid), longint'(e_yv));
      chk($sformatf("%s inpt_ready@%0d", name, rel), longint'(neuron_inpt_ready), longint'(e_rdy));
      if (rel != LAST || aborted)
        chk($sformatf("%s neuron_rst@%0d", name, rel), longint'(neuron_rst), longint'(e_nrst));
      if (e_yv) begin
        chk($sformatf("%s y_idx@%0d", name, rel), longint'(y_idx), longint'((rel - 1) / P - 1));
        chk($sformatf("%s y_data@%0d", name, rel), longint'($signed(y_data)), ref_y((rel - 1) / P - 1));
      end
      if (!aborted && in_run && ph == 0)
        chk($sformatf("%s b_addr@%0d", name, rel), longint'(b_addr), longint'(k));
      if (!aborted && in_run && ph >= 1 && ph <= NI) begin
        chk($sformatf("%s w_addr@%0d", name, rel), longint'(w_addr), longint'(k * NI + jj));
        chk($sformatf("%s x_addr@%0d", name, rel), longint'(x_addr), longint'(jj));
      end
      if (aborted && rel == rst_rel + 1) begin
        chk($sformatf("%s y_data_rst", name), longint'(y_data), 0);
        chk($sformatf("%s y_idx_rst", name), longint'(y_idx), 0);
        chk($sformatf("%s w_addr_rst", name), longint'(w_addr), 0);
      end
      start = (rel == 0) || (rel == busy_rel);
      rst_n = (rel != rst_rel);
      @(posedge clk);
      @(negedge clk);
    end
    start = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic load_basic();
    w_mem[0] = 10'sd256; w_mem[1] = 10'sd256; w_mem[2] = 10'sd256; w_mem[3] = -10'sd256;
    x_mem[0] = 10'sd256; x_mem[1] = 10'sd256;
    b_mem[0] = 10'sd0;   b_mem[1] = 10'sd128;
  endtask

  initial begin
    load_basic();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst busy", longint'(busy), 0);
    chk("rst done", longint'(done), 0);
    chk("rst y_valid", longint'(y_valid), 0);
    chk("rst inpt_ready", longint'(neuron_inpt_ready), 0);
    chk("rst neuron_rst", longint'(neuron_rst), 1);
    chk("rst y_data", longint'(y_data), 0);
    chk("rst y_idx", longint'(y_idx), 0);
    chk("rst addr", longint'({w_addr, x_addr, b_addr}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    chk("basic ref y0", ref_y(0), 256);
    chk("basic ref y1", ref_y(1), 128);
    run("basic", -1, -1);
    run("start_busy", 4, -1);
    run("rst_mid", -1, 8);
    run("after_rst", -1, -1);
    run("b2b", -1, -1);

    for (int i = 0; i < NI * NN; i++) w_mem[i] = '0;
    b_mem[0] = -10'sd128;
    b_mem[1] = 10'sd0;
    chk("negbias ref y0", ref_y(0), -128);
    run("negbias", -1, -1);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NI * NN; i++) w_mem[i] = N'($urandom());
      for (int i = 0; i < NI; i++) x_mem[i] = N'($urandom());
      for (int i = 0; i < NN; i++) b_mem[i] = N'($urandom());
      run($sformatf("rand%0d", r), (r % 2 == 1) ? int'($urandom_range(1, LAST)) : -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
